// File: rtl/fifo_stream_out_pkg.sv
// Shared resize-path constants: image geometry and word width used by the
// pixel-to-FIFO writer and the FIFO-to-stream reader.
package fifo_stream_out_pkg;

   localparam int unsigned DEF_DATA_W   = 64;
   localparam int unsigned DEF_LINE_PIX = 416;
   localparam int unsigned DEF_LINES    = 416;

   // Output skid buffer geometry
   localparam int unsigned SKID_DEPTH = 2;
   localparam int unsigned SKID_CNT_W = 2;

   // Counter width able to hold 0..n-1, never narrower than one bit
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry in-order buffer between FIFO read data and the output stream.
// The producer only pushes when it has reserved space, so in_valid is never refused.
module stream_skid_buf
   import fifo_stream_out_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [DATA_W-1:0]     in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_W-1:0]     out_data,
   output logic [SKID_CNT_W-1:0] count
);

   logic [DATA_W-1:0]     slot0_q;
   logic [DATA_W-1:0]     slot1_q;
   logic [SKID_CNT_W-1:0] count_q;
   logic                  push_c;
   logic                  pop_c;

   assign push_c    = in_valid;
   assign pop_c     = out_ready & (count_q != '0);
   assign out_valid = (count_q != '0);
   assign out_data  = slot0_q;
   assign count     = count_q;

   // slot0 is always the oldest word; a pop shifts slot1 forward
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot0_q <= '0;
         slot1_q <= '0;
         count_q <= '0;
      end else begin
         case ({push_c, pop_c})
            2'b10: begin
               if (count_q == '0) slot0_q <= in_data;
               else               slot1_q <= in_data;
               count_q <= count_q + SKID_CNT_W'(1);
            end
            2'b01: begin
               slot0_q <= slot1_q;
               count_q <= count_q - SKID_CNT_W'(1);
            end
            2'b11: begin
               if (count_q == SKID_CNT_W'(1)) begin
                  slot0_q <= in_data;
               end else begin
                  slot0_q <= slot1_q;
                  slot1_q <= in_data;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/fifo_stream_out.sv
// Drains pixel words from the resize FIFO (standard read latency of one cycle)
// and presents them as a line/frame-framed ready/valid stream.
module fifo_stream_out
   import fifo_stream_out_pkg::*;
#(
   parameter int unsigned DATA_W   = DEF_DATA_W,
   parameter int unsigned LINE_PIX = DEF_LINE_PIX,
   parameter int unsigned LINES    = DEF_LINES
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_dout,
   output logic              fifo_rd_en,
   output logic [DATA_W-1:0] m_tdata,
   output logic              m_tvalid,
   input  logic              m_tready,
   output logic              m_tlast,
   output logic              m_tuser,
   output logic              frame_done
);

   localparam int unsigned X_W   = cnt_w(LINE_PIX);
   localparam int unsigned Y_W   = cnt_w(LINES);
   localparam int unsigned PND_W = SKID_CNT_W + 1;

   logic                  in_flight_q;
   logic [SKID_CNT_W-1:0] buf_count;
   logic [SKID_CNT_W-1:0] kept_c;
   logic [PND_W-1:0]      pending_c;
   logic                  xfer_c;
   logic                  x_last_c;
   logic                  y_last_c;
   logic [X_W-1:0]        x_q;
   logic [Y_W-1:0]        y_q;
   logic                  frame_done_q;

   stream_skid_buf #(
      .DATA_W (DATA_W)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_flight_q),
      .in_data   (fifo_dout),
      .out_valid (m_tvalid),
      .out_ready (m_tready),
      .out_data  (m_tdata),
      .count     (buf_count)
   );

   // A word leaving this cycle frees its slot, so back-to-back reads sustain full rate
   always_comb begin
      xfer_c     = m_tvalid & m_tready;
      kept_c     = buf_count - SKID_CNT_W'(xfer_c);
      pending_c  = PND_W'(kept_c) + PND_W'(in_flight_q);
      fifo_rd_en = 1'b0;
      if (!rst && en && !fifo_empty && (pending_c < PND_W'(SKID_DEPTH))) begin
         fifo_rd_en = 1'b1;
      end
   end

   // Tracks the read whose data appears on fifo_dout next cycle, independent of en
   always_ff @(posedge clk or posedge rst) begin
      if (rst) in_flight_q <= 1'b0;
      else     in_flight_q <= fifo_rd_en;
   end

   assign x_last_c = (x_q == X_W'(LINE_PIX - 1));
   assign y_last_c = (y_q == Y_W'(LINES - 1));

   // Pixel/line position of the word currently at the stream head
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_q <= '0;
         y_q <= '0;
      end else if (xfer_c) begin
         if (x_last_c) begin
            x_q <= '0;
            y_q <= y_last_c ? '0 : y_q + Y_W'(1);
         end else begin
            x_q <= x_q + X_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) frame_done_q <= 1'b0;
      else     frame_done_q <= xfer_c & x_last_c & y_last_c;
   end

   assign m_tlast    = x_last_c;
   assign m_tuser    = (x_q == '0) && (y_q == '0);
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fifo_stream_out.sv
// Scoreboard bench for fifo_stream_out: a queue-based FIFO model feeds the DUT,
// expected beats with framing are queued on load and retired on each transfer.
module tb_fifo_stream_out;

   localparam int DATA_W   = 64;
   localparam int LINE_PIX = 4;
   localparam int LINES    = 2;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              tlast;
      logic              tuser;
      logic              eof;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              en = 1'b0;
   logic              fifo_empty = 1'b1;
   logic              m_tready = 1'b0;
   logic [DATA_W-1:0] fifo_dout = '0;
   logic              fifo_rd_en;
   logic [DATA_W-1:0] m_tdata;
   logic              m_tvalid;
   logic              m_tlast;
   logic              m_tuser;
   logic              frame_done;

   always #5 clk = ~clk;

   fifo_stream_out #(
      .DATA_W   (DATA_W),
      .LINE_PIX (LINE_PIX),
      .LINES    (LINES)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .fifo_empty (fifo_empty),
      .fifo_dout  (fifo_dout),
      .fifo_rd_en (fifo_rd_en),
      .m_tdata    (m_tdata),
      .m_tvalid   (m_tvalid),
      .m_tready   (m_tready),
      .m_tlast    (m_tlast),
      .m_tuser    (m_tuser),
      .frame_done (frame_done)
   );

   logic [DATA_W-1:0] fifo_q[$];
   exp_t              exp_q[$];

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0, n_rd = 0, n_xfer = 0, n_fd = 0, n_tuser = 0, outst = 0;
   int bx = 0, by = 0;
   int first_rd = -1, first_v = -1, last_xfer_cyc = -1;
   bit rd_seen = 0, fd_pend = 0, gate = 0;
   bit en_knob = 0, rst_knob = 1, ready_knob = 0, rand_ready = 0, toggle_empty = 0;
   logic [DATA_W-1:0] last_data = '0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, want, cyc);
      end
   endtask

   task automatic push_word(input logic [DATA_W-1:0] d);
      exp_t e;
      e.data  = d;
      e.tlast = (bx == LINE_PIX - 1);
      e.tuser = (bx == 0) && (by == 0);
      e.eof   = e.tlast && (by == LINES - 1);
      fifo_q.push_back(d);
      exp_q.push_back(e);
      if (bx == LINE_PIX - 1) begin
         bx = 0;
         by = (by == LINES - 1) ? 0 : by + 1;
      end else begin
         bx++;
      end
   endtask

   // Observe one settled cycle: framing, data order, read legality
   task automatic monitor();
      exp_t e;
      chk("frame_done", 64'(frame_done), 64'(fd_pend));
      if (frame_done) n_fd++;
      fd_pend = 0;
      if (fifo_rd_en && first_rd < 0) first_rd = cyc;
      if (m_tvalid && first_v < 0) first_v = cyc;
      if (m_tvalid) begin
         if (exp_q.size() == 0) begin
            chk("spurious_tvalid", 64'(m_tvalid), 64'd0);
         end else begin
            e = exp_q[0];
            chk("tdata", m_tdata, e.data);
            chk("tlast", 64'(m_tlast), 64'(e.tlast));
            chk("tuser", 64'(m_tuser), 64'(e.tuser));
            if (m_tready) begin
               void'(exp_q.pop_front());
               fd_pend = e.eof;
               n_xfer++;
               outst--;
               last_xfer_cyc = cyc;
               last_data = m_tdata;
               if (m_tuser) n_tuser++;
            end
         end
      end
      if (fifo_rd_en) begin
         chk("rd_legal", 64'({en, fifo_empty}), 64'(2'b10));
         rd_seen = 1;
         n_rd++;
         outst++;
      end
      chk("occupancy", 64'(outst <= 2), 64'd1);
   endtask

   // One clock: model FIFO read data, apply knobs after the edge, check at negedge
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (rd_seen) begin
         if (fifo_q.size() != 0) fifo_dout = fifo_q.pop_front();
         rd_seen = 0;
      end
      rst = rst_knob;
      if (rst_knob) begin
         fifo_q.delete();
         exp_q.delete();
         bx = 0;
         by = 0;
         fd_pend = 0;
         outst = 0;
      end
      en       = en_knob;
      m_tready = rand_ready ? 1'($urandom_range(0, 1)) : ready_knob;
      gate     = toggle_empty ? ~gate : 1'b0;
      fifo_empty = gate || (fifo_q.size() == 0);
      @(negedge clk);
      monitor();
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         step();
         n++;
      end
      chk("drain_timeout", 64'(exp_q.size()), 64'd0);
      step();
   endtask

   initial begin
      int r0, x0, t0, n;

      // Reset values
      rst_knob = 1;
      step();
      step();
      chk("rst_tvalid", 64'(m_tvalid), 64'd0);
      chk("rst_tdata", m_tdata, 64'd0);
      chk("rst_rd_en", 64'(fifo_rd_en), 64'd0);
      chk("rst_frame_done", 64'(frame_done), 64'd0);
      chk("rst_tuser", 64'(m_tuser), 64'd1);
      chk("rst_tlast", 64'(m_tlast), 64'd0);
      rst_knob = 0;
      step();

      // Preloaded frame, full throughput
      for (int i = 1; i <= 8; i++) push_word(64'(i));
      en_knob = 1;
      ready_knob = 1;
      drain(50);
      chk("latency", 64'(first_v - first_rd), 64'd2);
      chk("throughput", 64'(last_xfer_cyc - first_v), 64'd7);
      chk("frame_done_count", 64'(n_fd), 64'd1);

      // Downstream stall mid-stream
      for (int i = 1; i <= 8; i++) push_word(64'(100 + i));
      repeat (3) step();
      ready_knob = 0;
      r0 = n_rd;
      repeat (5) step();
      chk("stall_reads", 64'(n_rd - r0 <= 2), 64'd1);
      chk("stall_rd_en", 64'(fifo_rd_en), 64'd0);
      chk("stall_tvalid", 64'(m_tvalid), 64'd1);
      ready_knob = 1;
      drain(50);

      // en dropped right after a read
      en_knob = 0;
      for (int i = 1; i <= 4; i++) push_word(64'(200 + i));
      repeat (2) step();
      r0 = n_rd;
      en_knob = 1;
      step();
      chk("en_pulse_reads", 64'(n_rd - r0), 64'd1);
      en_knob = 0;
      r0 = n_rd;
      x0 = n_xfer;
      repeat (6) step();
      chk("en_low_reads", 64'(n_rd - r0), 64'd0);
      chk("inflight_delivered", 64'(n_xfer - x0), 64'd1);
      en_knob = 1;
      drain(50);

      // Bursty FIFO and random backpressure across a frame wrap
      toggle_empty = 1;
      rand_ready = 1;
      t0 = n_tuser;
      for (int i = 0; i < 16; i++) push_word({$urandom, $urandom});
      drain(400);
      chk("wrap_tuser_count", 64'(n_tuser - t0), 64'd2);
      toggle_empty = 0;
      rand_ready = 0;

      // Upper padding bits pass through untouched
      push_word(64'hFFFF_FF00_00AB_CDEF);
      drain(20);
      chk("passthru", last_data, 64'hFFFF_FF00_00AB_CDEF);

      // Reset mid-frame
      for (int i = 1; i <= 8; i++) push_word(64'(300 + i));
      x0 = n_xfer;
      n = 0;
      while (n_xfer - x0 < 3 && n < 50) begin
         step();
         n++;
      end
      chk("pre_rst_xfers", 64'(n_xfer - x0), 64'd3);
      rst_knob = 1;
      step();
      chk("midrst_tvalid", 64'(m_tvalid), 64'd0);
      chk("midrst_tdata", m_tdata, 64'd0);
      chk("midrst_rd_en", 64'(fifo_rd_en), 64'd0);
      chk("midrst_frame_done", 64'(frame_done), 64'd0);
      chk("midrst_tuser", 64'(m_tuser), 64'd1);
      rst_knob = 0;
      step();
      t0 = n_tuser;
      for (int i = 1; i <= 8; i++) push_word(64'(400 + i));
      drain(60);
      chk("post_rst_tuser", 64'(n_tuser - t0), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fifo_stream_out.md
FIFO_STREAM_OUT -- requirements
Module: fifo_stream_out

Purpose: downstream neighbour of the pixel-to-FIFO writer. Drains 64-bit zero-padded pixel words from the resize FIFO and presents them as a line/frame-framed ready/valid stream.

Interface
REQ-001 Parameter DATA_W, default 64, FIFO and stream word width.
REQ-002 Parameter LINE_PIX, default 416, pixels (words) per line.
REQ-003 Parameter LINES, default 416, lines per frame.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 en  input  1  high permits new FIFO reads; low stops reads only.
REQ-007 fifo_empty  input  1  FIFO empty flag.
REQ-008 fifo_dout  input  DATA_W  FIFO read data, valid exactly one cycle after a rd_en cycle (standard, non-FWFT).
REQ-009 fifo_rd_en  output  1  FIFO read strobe.
REQ-010 m_tdata  output  DATA_W  stream data.
REQ-011 m_tvalid  output  1  stream data valid.
REQ-012 m_tready  input  1  downstream accept.
REQ-013 m_tlast  output  1  high on the last pixel of each line.
REQ-014 m_tuser  output  1  high on the first pixel of each frame.
REQ-015 frame_done  output  1  one-cycle pulse when the last pixel of a frame is accepted.

Function
REQ-016 The block SHALL assert fifo_rd_en only when en=1, fifo_empty=0, and (stored words + in-flight reads) < 2.
REQ-017 In-flight reads SHALL be captured one cycle after rd_en, including when en falls in between.
REQ-018 Buffering SHALL be a 2-entry in-order buffer; no word is ever dropped, duplicated, or reordered.
REQ-019 m_tvalid SHALL be high whenever the buffer holds at least one word; m_tdata SHALL be the oldest word.
REQ-020 While m_tvalid=1 and m_tready=0, m_tdata/m_tlast/m_tuser SHALL hold stable.
REQ-021 A transfer SHALL occur on any cycle with m_tvalid=1 and m_tready=1; simultaneous transfer and capture SHALL keep occupancy unchanged.
REQ-022 Pixel counter x (0..LINE_PIX-1) and line counter y (0..LINES-1) SHALL advance only on transfer.
REQ-023 x SHALL wrap from LINE_PIX-1 to 0 and increment y; y SHALL wrap from LINES-1 to 0.
REQ-024 m_tlast SHALL equal (x==LINE_PIX-1); m_tuser SHALL equal (x==0 && y==0), both combinational on the counters.
REQ-025 frame_done SHALL pulse for one cycle, registered, on the cycle after a transfer with x==LINE_PIX-1 and y==LINES-1.
REQ-026 Throughput SHALL be one word per cycle with sustained m_tready=1 and a non-empty FIFO.
REQ-027 Latency SHALL be 2 cycles from the first rd_en to m_tvalid: rd_en at cycle N, data captured at N+1, m_tvalid at N+2.
REQ-028 Payload SHALL pass through unmodified: bits [63:24] remain as received; no padding check.

Reset
REQ-029 On rst, fifo_rd_en=0, m_tvalid=0, m_tdata=0, frame_done=0, x=0, y=0, buffer empty, in-flight flag cleared.
REQ-030 Reset mid-frame SHALL discard buffered and in-flight words; the first post-reset transfer SHALL carry m_tuser=1.

Structure
REQ-031 LINE_PIX, LINES, and DATA_W defaults SHALL live in the shared resize constants package, used by both the writer and this block.
REQ-032 The 2-entry buffer SHALL be one sub-module, stream_skid_buf (occupancy count, in_valid, out_valid/out_ready); counters and read control stay in the top.

Verification (bench parameters LINE_PIX=4, LINES=2)
REQ-033 FIFO preloaded with words 1..8, m_tready=1, en=1 -> outputs 1..8 on consecutive cycles; tuser on 1; tlast on 4 and 8; frame_done one cycle after 8 is accepted.
REQ-034 m_tready=0 for 5 cycles mid-stream -> at most 2 reads issued, then rd_en=0; data held stable; order preserved on release.
REQ-035 en dropped in the same cycle as a rd_en -> the in-flight word is still delivered; no further reads until en=1.
REQ-036 fifo_empty toggling every cycle with m_tready random -> output sequence equals input sequence; x/y framing correct across the frame wrap (second frame starts with tuser=1).
REQ-037 rst pulsed after 3 transfers -> outputs return to reset values immediately; the next transfer has tuser=1 and x restarts at 0.
REQ-038 Word 0xFFFFFF0000ABCDEF written -> emitted unchanged.
